jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//  Shares one bank of NBITS JK flip-flops between NREQ requesters. Each requester posts a
//  per-bit J/K command vector with a valid/ready handshake. A round-robin arbiter accepts
//  at most one command per clock and applies it to the bank with JK semantics.
//  Sits between command sources and any logic that consumes the shared q state.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  NBITS  8  width of the JK flop bank
//  CW     8  grant-counter width (used only when JKARB_STATS_EN is defined)
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           synchronous, active-high
//  req_valid  in   NREQ        requester i has a command pending
//  req_j      in   NREQ*NBITS  J vector; requester i uses slice [i*NBITS +: NBITS]
//  req_k      in   NREQ*NBITS  K vector, same slicing
//  req_ready  out  NREQ        one-hot (or 0) combinational grant; transfer = valid&ready
//  q          out  NBITS       registered flop-bank state
//  gnt_valid  out  1           registered: a transfer happened on the previous edge
//  gnt_id     out  clog2(NREQ) registered: index of the last accepted requester
//  grant_cnt  out  CW          total accepted commands (present only with JKARB_STATS_EN)
// BEHAVIOUR
//  - Reset (sync, high): q=0, rr pointer ptr=0, gnt_valid=0, gnt_id=0, grant_cnt=0.
//    req_ready is forced to 0 while reset=1. Reset beats any command on the same edge.
//  - Arbitration (combinational): winner = first i with req_valid[i], scanning
//    ptr, ptr+1, ... mod NREQ. req_ready[winner]=1, all other bits 0. No valid -> req_ready=0.
//  - req_ready[i] may depend on req_valid (no combinational loop allowed on the
//    requester side). A requester keeps valid and its J/K stable until it is granted.
//  - On an edge with a transfer from requester w, per bit b, with j=req_j[w*NBITS+b],
//    k=req_k[w*NBITS+b]:
//    j=0,k=0 -> q[b] holds; 0,1 -> q[b]=0; 1,0 -> q[b]=1; 1,1 -> q[b]=~q[b].
//    Then ptr <= (w+1) mod NREQ, gnt_valid<=1, gnt_id<=w.
//  - No transfer: q and ptr hold, gnt_valid<=0, gnt_id holds.
//  - Latency: the command is applied on the edge of the handshake, and the new q is visible
//    the same cycle that gnt_valid=1. Throughput is 1 command/clock.
//  - Fairness: with all NREQ valid continuously, grants go 0,1,..,NREQ-1,0,...
//    Starvation is bounded by NREQ-1 cycles.
//  - ptr wrap: (NREQ-1)+1 -> 0. This must hold for non-power-of-2 NREQ.
// CONFIGURATION
//  Macro JKARB_STATS_EN.
//  - Defined: the grant_cnt port exists. It increments by 1 per transfer and saturates
//    at 2^CW-1 (no wrap). Reset clears it to 0.
//  - Undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared include jk_bank_defs.vh holds:
//    - JK command encodings (JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11).
//    - The default NREQ/NBITS values.
//  - One sub-module, jk_rr_arbiter (NREQ): inputs clk, reset, req_valid; outputs
//    gnt one-hot and gnt_idx. It owns ptr. The top holds the q bank, the mux and the stats.
// TESTING (NREQ=4, NBITS=8, CW=8)
//  1. reset=1 for 2 clk with req_valid=4'b1111 -> req_ready=0, q=8'h00, gnt_valid=0.
//  2. Only req2 valid, j=8'hF0, k=8'h00 -> req_ready=4'b0100. Next cycle:
//     q=8'hF0, gnt_valid=1, gnt_id=2.
//  3. All four valid for 5 clk after reset -> gnt_id sequence 0,1,2,3,0 (ptr wraps).
//  4. q=8'hF0, then j=k=8'hFF -> q=8'h0F. Then j=8'h00, k=8'h0C -> q=8'h03.
//     Then j=k=0 -> q stays 8'h03.
//  5. Mid-stream reset pulse while ptr=3 -> q=8'h00. The first grant after reset goes to
//     req0 when all are valid.
//  6. JKARB_STATS_EN: 300 back-to-back transfers -> grant_cnt=255 and stays there.
//     Macro undefined -> the bench builds without grant_cnt.

Source files
------------

// File: rtl/jk_bank_arbiter_pkg.sv
// rtl/jk_bank_arbiter_pkg.sv - shared JK command encodings, default sizes and JK update helper
// Purpose: common definitions for the JK flop-bank arbiter slice.
//   JK_HOLD/JK_CLR/JK_SET/JK_TOG : 2-bit {j,k} command encodings
//   DEF_NREQ / DEF_NBITS         : default requester count and bank width
//   jk_next()                    : next state of one JK flop for a {j,k} command
// Ports: none (package).
package jk_bank_arbiter_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_NBITS = 8;

   function automatic logic jk_next(input logic q, input logic [1:0] jk);
      logic nq;
      case (jk)
         JK_HOLD: nq = q;
         JK_CLR:  nq = 1'b0;
         JK_SET:  nq = 1'b1;
         default: nq = ~q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr.sv
// rtl/jk_bank_arbiter_rr.sv - round-robin grant generator owning the rotating priority pointer
// Purpose: picks the first valid requester starting at ptr and advances ptr past the winner.
// Module name: jk_rr_arbiter
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; forces gnt to 0 and clears ptr
//   req_valid  in   [NREQ]     pending requests
//   gnt        out  [NREQ]     one-hot (or 0) combinational grant
//   gnt_idx    out  [clog2]    index of the granted requester (0 when none)
module jk_rr_arbiter
   import jk_bank_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   gnt_idx
);

   localparam int IW = $clog2(NREQ);
   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW:0]   cand;
   logic          found;

   // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-2 NREQ works.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(off);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!found && !reset && req_valid[cand[IW-1:0]]) begin
            found                = 1'b1;
            gnt_idx              = cand[IW-1:0];
            gnt[cand[IW-1:0]]    = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - NREQ requesters sharing one JK flop bank through a round-robin arbiter
// Purpose: accepts at most one J/K command vector per clock and applies it to the bank.
// Optional feature: macro JKARB_STATS_EN adds the saturating grant_cnt output.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   req_valid  in   [NREQ]        command pending per requester
//   req_j      in   [NREQ*NBITS]  J vectors, requester i at [i*NBITS +: NBITS]
//   req_k      in   [NREQ*NBITS]  K vectors, same slicing
//   req_ready  out  [NREQ]        one-hot combinational grant
//   q          out  [NBITS]       registered bank state
//   gnt_valid  out                a transfer happened on the previous edge
//   gnt_id     out  [clog2]       index of the last accepted requester
//   grant_cnt  out  [CW]          saturating transfer count (JKARB_STATS_EN only)
module jk_bank_arbiter
   import jk_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int NBITS = DEF_NBITS,
   parameter int CW    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*NBITS-1:0]     req_j,
   input  logic [NREQ*NBITS-1:0]     req_k,
   output logic [NREQ-1:0]           req_ready,
   output logic [NBITS-1:0]          q,
   output logic                      gnt_valid,
   output logic [$clog2(NREQ)-1:0]   gnt_id
`ifdef JKARB_STATS_EN
   ,
   output logic [CW-1:0]             grant_cnt
`endif
);

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic             xfer;
   logic [NBITS-1:0] sel_j;
   logic [NBITS-1:0] sel_k;
   logic [NBITS-1:0] q_d;
   logic [NBITS-1:0] q_q;
   logic             gnt_valid_q;
   logic [IW-1:0]    gnt_id_q;

   jk_rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx)
   );

   // gnt is only ever set on a valid requester, so any grant bit is a transfer.
   assign xfer      = |gnt;
   assign req_ready = gnt;

   // One-hot AND-OR mux of the winning requester's J/K slices.
   always_comb begin
      sel_j = '0;
      sel_k = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_j = sel_j | req_j[i*NBITS +: NBITS];
            sel_k = sel_k | req_k[i*NBITS +: NBITS];
         end
      end
   end

   always_comb begin
      q_d = q_q;
      for (int b = 0; b < NBITS; b++) begin
         q_d[b] = jk_next(q_q[b], {sel_j[b], sel_k[b]});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q         <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
      end else begin
         gnt_valid_q <= xfer;
         if (xfer) begin
            q_q      <= q_d;
            gnt_id_q <= gnt_idx;
         end
      end
   end

   assign q         = q_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;

`ifdef JKARB_STATS_EN
   logic [CW-1:0] grant_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt_q <= '0;
      end else if (xfer && (grant_cnt_q != {CW{1'b1}})) begin
         grant_cnt_q <= grant_cnt_q + 1'b1;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - scoreboard bench for jk_bank_arbiter with a reference model
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int NBITS = 8;
   localparam int CW    = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*NBITS-1:0] req_j;
   logic [NREQ*NBITS-1:0] req_k;
   logic [NREQ-1:0]       req_ready;
   logic [NBITS-1:0]      q;
   logic                  gnt_valid;
   logic [1:0]            gnt_id;
`ifdef JKARB_STATS_EN
   logic [CW-1:0]         grant_cnt;
`endif

   jk_bank_arbiter #(
      .NREQ  (NREQ),
      .NBITS (NBITS),
      .CW    (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_j     (req_j),
      .req_k     (req_k),
      .req_ready (req_ready),
      .q         (q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
`ifdef JKARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       gv;
      bit [7:0] q;
      int       gid;
      int       cnt;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Requester-side state: each requester keeps its command until granted.
   bit       pv [NREQ];
   bit [7:0] pj [NREQ];
   bit [7:0] pk [NREQ];

   // Reference model state.
   int       mptr = 0;
   bit [7:0] mq   = 0;
   int       mgid = 0;
   int       mcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]              = pv[i];
         req_j[i*NBITS +: NBITS]   = pj[i];
         req_k[i*NBITS +: NBITS]   = pk[i];
      end
   endtask

   task automatic refill(input int i);
      pv[i] = 1'b1;
      pj[i] = 8'($urandom);
      pk[i] = 8'($urandom);
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic step(input bit rst, output int w);
      logic [NREQ-1:0] exp_rdy;
      exp_t e;
      reset = rst;
      drive();
      #3;
      w = -1;
      if (!rst) begin
         for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (mptr + off) % NREQ;
            if (w < 0 && pv[i]) w = i;
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (rst) begin
         mq = 0; mptr = 0; mgid = 0; mcnt = 0;
         e.gv = 0;
      end else if (w >= 0) begin
         mq   = (pj[w] & ~mq) | (~pk[w] & mq);
         mptr = (w + 1) % NREQ;
         mgid = w;
         if (mcnt < (1 << CW) - 1) mcnt++;
         e.gv = 1;
         pv[w] = 1'b0;
      end else begin
         e.gv = 0;
      end
      e.q = mq; e.gid = mgid; e.cnt = mcnt;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every expectation describes the outputs right after one edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("gnt_valid", 32'(gnt_valid), 32'(e.gv));
         chk("q", 32'(q), 32'(e.q));
         chk("gnt_id", 32'(gnt_id), 32'(e.gid));
`ifdef JKARB_STATS_EN
         chk("grant_cnt", 32'(grant_cnt), 32'(e.cnt));
`endif
      end
   end

   int w;
   int seq_exp [5] = '{0, 1, 2, 3, 0};

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_j     = '0;
      req_k     = '0;
      for (int i = 0; i < NREQ; i++) refill(i);
      drive();
      @(posedge clk);
      #1;

      // Reset with every requester valid.
      step(1'b1, w);
      step(1'b1, w);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);

      // Single requester 2.
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      pv[2] = 1'b1; pj[2] = 8'hF0; pk[2] = 8'h00;
      reset = 1'b0;
      drive();
      #1;
      chk("solo_ready", 32'(req_ready), 32'h4);
      #(-0);
      step(1'b0, w);
      chk("solo_q", 32'(q), 32'hF0);
      chk("solo_gv", 32'(gnt_valid), 32'h1);
      chk("solo_id", 32'(gnt_id), 32'h2);

      // JK toggle / clear / hold.
      pv[1] = 1'b1; pj[1] = 8'hFF; pk[1] = 8'hFF;
      step(1'b0, w);
      chk("tog_q", 32'(q), 32'h0F);
      pv[1] = 1'b1; pj[1] = 8'h00; pk[1] = 8'h0C;
      step(1'b0, w);
      chk("clr_q", 32'(q), 32'h03);
      pv[1] = 1'b1; pj[1] = 8'h00; pk[1] = 8'h00;
      step(1'b0, w);
      chk("hold_q", 32'(q), 32'h03);

      // Fairness and pointer wrap with all valid.
      step(1'b1, w);
      for (int i = 0; i < NREQ; i++) refill(i);
      for (int n = 0; n < 5; n++) begin
         step(1'b0, w);
         refill(w);
         chk("rr_seq", 32'(gnt_id), 32'(seq_exp[n]));
      end

      // Advance pointer to 3, then reset mid-stream.
      step(1'b0, w); refill(w);
      step(1'b0, w); refill(w);
      chk("pre_rst_id", 32'(gnt_id), 32'h2);
      step(1'b1, w);
      chk("mid_rst_q", 32'(q), 32'h00);
      step(1'b0, w); refill(w);
      chk("post_rst_id", 32'(gnt_id), 32'h0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         bit r;
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && ($urandom % 2 == 0)) refill(i);
         end
         r = ($urandom % 150 == 0);
         step(r, w);
      end

`ifdef JKARB_STATS_EN
      step(1'b1, w);
      for (int i = 0; i < NREQ; i++) refill(i);
      for (int n = 0; n < 300; n++) begin
         step(1'b0, w);
         refill(w);
      end
      chk("cnt_sat", 32'(grant_cnt), 32'd255);
      for (int n = 0; n < 5; n++) begin
         step(1'b0, w);
         refill(w);
      end
      chk("cnt_stay", 32'(grant_cnt), 32'd255);
`endif

      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      step(1'b0, w);
      #5;
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
